// File: rtl/mem_line_arbiter_if.sv
// rtl/mem_line_arbiter_if.sv - requester and RAM/IO port bundle for mem_line_arbiter
// slave is the arbiter side; master is the requester/RAM side.
interface mem_line_arbiter_if #(
  parameter int LINE_BYTES = 16
);
  logic                      valid_from_inst;
  logic [31:0]               addr_from_inst;
  logic                      ready_to_inst;
  logic [8*LINE_BYTES-1:0]   line_to_inst;

  logic                      valid_from_data;
  logic                      rw_flag_from_data;
  logic [31:0]               addr_from_data;
  logic [8*LINE_BYTES-1:0]   line_from_data;
  logic                      ready_to_data;
  logic [8*LINE_BYTES-1:0]   line_to_data;

  logic                      valid_from_io;
  logic                      rw_flag_from_io;
  logic [31:0]               addr_from_io;
  logic [7:0]                byte_from_io;
  logic                      ready_to_io;
  logic [7:0]                byte_to_io;

  logic [7:0]                mem_din;
  logic [7:0]                mem_dout;
  logic [31:0]               mem_a;
  logic                      mem_wr;
  logic                      io_buffer_full;

  modport slave (
    input  valid_from_inst, addr_from_inst,
    output ready_to_inst, line_to_inst,
    input  valid_from_data, rw_flag_from_data, addr_from_data, line_from_data,
    output ready_to_data, line_to_data,
    input  valid_from_io, rw_flag_from_io, addr_from_io, byte_from_io,
    output ready_to_io, byte_to_io,
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output valid_from_inst, addr_from_inst,
    input  ready_to_inst, line_to_inst,
    output valid_from_data, rw_flag_from_data, addr_from_data, line_from_data,
    input  ready_to_data, line_to_data,
    output valid_from_io, rw_flag_from_io, addr_from_io, byte_from_io,
    input  ready_to_io, byte_to_io,
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_line_arbiter.sv
// rtl/mem_line_arbiter.sv - serialises inst/data line and IO byte requests onto the byte-wide RAM/IO port
// Define MEM_RR_ARB_EN to round-robin data/inst ties (IO keeps top priority); default is fixed io > data > inst.
module mem_line_arbiter #(
  parameter int LINE_BYTES  = 16,
  parameter int OFFSET_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  mem_line_arbiter_if.slave bus
);
  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int CNT_W  = OFFSET_BITS + 1;
  localparam logic [CNT_W-1:0] CNT_WR_END  = CNT_W'(LINE_BYTES);
  localparam logic [CNT_W-1:0] CNT_RD_END  = CNT_W'(LINE_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_IO_END  = CNT_W'(2);
  localparam logic [31:0]      OFFSET_MASK = 32'(LINE_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LINE_READ, S_LINE_WRITE, S_IO_READ, S_IO_WRITE
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [31:0]            base_q;
  logic [LINE_W-1:0]      line_buf;
  logic [LINE_W-1:0]      line_cap;
  logic [OFFSET_BITS-1:0] cap_idx;
  logic [OFFSET_BITS-1:0] wr_idx;
  logic                   for_inst;
  logic                   mem_wr_q;
  logic                   io_ok;
  logic                   gnt_io, gnt_data, gnt_inst;
  logic [31:0]            line_base;

`ifdef MEM_RR_ARB_EN
  // High when inst won the last data/inst grant, so data wins the next tie.
  logic last_inst;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_inst <= 1'b1;
    end else if (rdy) begin
      if (gnt_data)      last_inst <= 1'b0;
      else if (gnt_inst) last_inst <= 1'b1;
    end
  end
`endif

  always_comb begin
    gnt_io   = 1'b0;
    gnt_data = 1'b0;
    gnt_inst = 1'b0;
    io_ok    = bus.valid_from_io && !(bus.rw_flag_from_io && bus.io_buffer_full);
    if (state == S_IDLE) begin
      if (io_ok) begin
        gnt_io = 1'b1;
      end else if (bus.valid_from_data && bus.valid_from_inst) begin
`ifdef MEM_RR_ARB_EN
        gnt_data = last_inst;
        gnt_inst = !last_inst;
`else
        gnt_data = 1'b1;
`endif
      end else if (bus.valid_from_data) begin
        gnt_data = 1'b1;
      end else if (bus.valid_from_inst) begin
        gnt_inst = 1'b1;
      end
    end
    line_base = (gnt_data ? bus.addr_from_data : bus.addr_from_inst) & ~OFFSET_MASK;
  end

  always_ff @(posedge clk) begin
    if (rst)      state <= S_IDLE;
    else if (rdy) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (gnt_io)        state_nxt = bus.rw_flag_from_io ? S_IO_WRITE : S_IO_READ;
        else if (gnt_data) state_nxt = bus.rw_flag_from_data ? S_LINE_WRITE : S_LINE_READ;
        else if (gnt_inst) state_nxt = S_LINE_READ;
      end
      S_LINE_READ:  if (cnt == CNT_RD_END) state_nxt = S_IDLE;
      S_LINE_WRITE: if (cnt == CNT_WR_END) state_nxt = S_IDLE;
      S_IO_READ:    if (cnt == CNT_IO_END) state_nxt = S_IDLE;
      S_IO_WRITE:   state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // RAM data lags the address by two edges, so counter value j captures byte j-2.
  always_comb begin
    cap_idx  = OFFSET_BITS'(cnt - CNT_W'(2));
    wr_idx   = cnt[OFFSET_BITS-1:0];
    line_cap = line_buf;
    line_cap[8*cap_idx +: 8] = bus.mem_din;
    bus.mem_wr = mem_wr_q & rdy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt               <= '0;
      base_q            <= '0;
      line_buf          <= '0;
      for_inst          <= 1'b0;
      mem_wr_q          <= 1'b0;
      bus.mem_a         <= '0;
      bus.mem_dout      <= '0;
      bus.ready_to_inst <= 1'b0;
      bus.ready_to_data <= 1'b0;
      bus.ready_to_io   <= 1'b0;
      bus.line_to_inst  <= '0;
      bus.line_to_data  <= '0;
      bus.byte_to_io    <= '0;
    end else if (rdy) begin
      bus.ready_to_inst <= 1'b0;
      bus.ready_to_data <= 1'b0;
      bus.ready_to_io   <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= CNT_W'(1);
          if (gnt_io) begin
            bus.mem_a    <= bus.addr_from_io;
            bus.mem_dout <= bus.byte_from_io;
            mem_wr_q     <= bus.rw_flag_from_io;
          end else if (gnt_data || gnt_inst) begin
            bus.mem_a <= line_base;
            base_q    <= line_base;
            for_inst  <= gnt_inst;
            line_buf  <= bus.line_from_data;
            if (gnt_data && bus.rw_flag_from_data) begin
              mem_wr_q     <= 1'b1;
              bus.mem_dout <= bus.line_from_data[7:0];
            end
          end
        end
        S_LINE_READ: begin
          cnt       <= cnt + CNT_W'(1);
          bus.mem_a <= base_q + 32'(cnt);
          if (cnt >= CNT_W'(2)) line_buf <= line_cap;
          if (cnt == CNT_RD_END) begin
            if (for_inst) begin
              bus.line_to_inst  <= line_cap;
              bus.ready_to_inst <= 1'b1;
            end else begin
              bus.line_to_data  <= line_cap;
              bus.ready_to_data <= 1'b1;
            end
          end
        end
        S_LINE_WRITE: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_WR_END) begin
            mem_wr_q          <= 1'b0;
            bus.ready_to_data <= 1'b1;
          end else begin
            bus.mem_a    <= base_q + 32'(cnt);
            bus.mem_dout <= line_buf[8*wr_idx +: 8];
          end
        end
        S_IO_READ: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_IO_END) begin
            bus.byte_to_io  <= bus.mem_din;
            bus.ready_to_io <= 1'b1;
          end
        end
        S_IO_WRITE: begin
          mem_wr_q        <= 1'b0;
          bus.ready_to_io <= 1'b1;
        end
        default: mem_wr_q <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb/tb_mem_line_arbiter.sv - self-checking bench for mem_line_arbiter with a byte RAM and transaction-level model
module tb_mem_line_arbiter;
  localparam int LB = 16;
  localparam int LW = 8 * LB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  always #5 clk = ~clk;

  mem_line_arbiter_if #(.LINE_BYTES(LB)) bus();
  mem_line_arbiter #(.LINE_BYTES(LB), .OFFSET_BITS(4)) dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

  // env_ram is the physical RAM behind the port; ref_mem is the bench's transaction-level expectation.
  logic [7:0] env_ram [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  bit         last_data = 1'b0;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int              kind;   // 0 inst rd, 1 data rd, 2 data wr, 3 io rd, 4 io wr
    logic [31:0]     addr;
    logic [LW-1:0]   wl;
    logic [7:0]      wb;
    int              lat;
    int              nwr;
    logic [LW-1:0]   rd;
  } vec_t;
  vec_t vecs[9];

  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return env_ram.exists(a) ? env_ram[a] : a[7:0];
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : a[7:0];
  endfunction

  function automatic logic [LW-1:0] ref_line(input logic [31:0] a);
    logic [LW-1:0] l;
    logic [31:0] b;
    b = a & ~32'(LB - 1);
    for (int k = 0; k < LB; k++) l[8*k +: 8] = ref_rd(b + 32'(k));
    return l;
  endfunction

  function automatic logic [LW-1:0] seq_line(input logic [7:0] start);
    logic [LW-1:0] l;
    for (int k = 0; k < LB; k++) l[8*k +: 8] = 8'(start + 8'(k));
    return l;
  endfunction

  function automatic int lat_of(input int kind);
    case (kind)
      0, 1:    return LB + 1;
      2:       return LB;
      3:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit ready_of(input int kind);
    if (kind == 0) return bus.ready_to_inst;
    if (kind <= 2) return bus.ready_to_data;
    return bus.ready_to_io;
  endfunction

  always @(posedge clk) begin
    bus.mem_din <= env_rd(bus.mem_a);
    if (bus.mem_wr) env_ram[bus.mem_a] = bus.mem_dout;
  end

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic txn(input int kind, input logic [31:0] addr, input logic [LW-1:0] wl, input logic [7:0] wb,
                     output int lat, output int nwr, output bit ok, output logic [LW-1:0] rd);
    logic [31:0] base;
    base = addr & ~32'(LB - 1);
    bus.addr_from_inst = addr;
    bus.addr_from_data = addr;
    bus.addr_from_io = addr;
    bus.line_from_data = wl;
    bus.byte_from_io = wb;
    bus.rw_flag_from_data = (kind == 2);
    bus.rw_flag_from_io = (kind == 4);
    bus.valid_from_inst = (kind == 0);
    bus.valid_from_data = (kind == 1 || kind == 2);
    bus.valid_from_io = (kind >= 3);
    lat = -1; nwr = 0; ok = 1'b1;
    @(posedge clk); #1;
    bus.valid_from_inst = 1'b0;
    bus.valid_from_data = 1'b0;
    bus.valid_from_io = 1'b0;
    bus.line_from_data = ~wl;
    bus.addr_from_data = ~addr;
    for (int k = 0; k < 40; k++) begin
      if (bus.mem_wr) begin
        nwr++;
        if (kind == 2 && (k >= LB || bus.mem_dout !== wl[8*(k%LB) +: 8])) ok = 1'b0;
        if (kind == 4 && bus.mem_dout !== wb) ok = 1'b0;
        if (kind < 2 || kind == 3) ok = 1'b0;
      end
      if (kind <= 2 && k < LB && bus.mem_a !== base + 32'(k)) ok = 1'b0;
      if (kind >= 3 && k == 0 && bus.mem_a !== addr) ok = 1'b0;
      if (ready_of(kind)) begin lat = k; break; end
      @(posedge clk); #1;
    end
    rd = (kind == 0) ? bus.line_to_inst : (kind <= 2) ? bus.line_to_data : LW'(bus.byte_to_io);
    if (kind == 2) for (int k = 0; k < LB; k++) ref_mem[base + 32'(k)] = wl[8*k +: 8];
    if (kind == 4) ref_mem[addr] = wb;
    if (kind <= 2) last_data = (kind != 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int lat, nwr, t_d, t_i, t_io, nblk;
    bit ok, data_first;
    logic [LW-1:0] rd;

    vecs[0] = '{0, 32'h0000_1234, '0, 8'h00, 17, 0, seq_line(8'h30)};
    vecs[1] = '{2, 32'h0000_2000, seq_line(8'hA0), 8'h00, 16, 16, '0};
    vecs[2] = '{1, 32'h0000_2007, '0, 8'h00, 17, 0, seq_line(8'hA0)};
    vecs[3] = '{0, 32'h0000_2000, '0, 8'h00, 17, 0, seq_line(8'hA0)};
    vecs[4] = '{3, 32'h0003_0004, '0, 8'h00, 2, 0, LW'(8'h7F)};
    vecs[5] = '{4, 32'h0003_0000, '0, 8'h41, 1, 1, '0};
    vecs[6] = '{3, 32'h0003_0000, '0, 8'h00, 2, 0, LW'(8'h41)};
    vecs[7] = '{0, 32'hFFFF_FFFF, '0, 8'h00, 17, 0, seq_line(8'hF0)};
    vecs[8] = '{3, 32'h0000_2003, '0, 8'h00, 2, 0, LW'(8'hA3)};

    env_ram[32'h0003_0004] = 8'h7F;
    ref_mem[32'h0003_0004] = 8'h7F;
    bus.valid_from_inst = 0; bus.addr_from_inst = 0;
    bus.valid_from_data = 0; bus.rw_flag_from_data = 0; bus.addr_from_data = 0; bus.line_from_data = 0;
    bus.valid_from_io = 0; bus.rw_flag_from_io = 0; bus.addr_from_io = 0; bus.byte_from_io = 0;
    bus.io_buffer_full = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {bus.ready_to_inst, bus.ready_to_data, bus.ready_to_io, bus.mem_wr}, 4'b0);
    check("rst_mem_a_dout", {bus.mem_a, bus.mem_dout}, 40'h0);
    check("rst_line_inst", bus.line_to_inst, '0);
    check("rst_line_data_byte", {bus.line_to_data, bus.byte_to_io}, '0);
    rst = 0;

    for (int i = 0; i < 9; i++) begin
      txn(vecs[i].kind, vecs[i].addr, vecs[i].wl, vecs[i].wb, lat, nwr, ok, rd);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_mem_wr_cycles", i), nwr, vecs[i].nwr);
      check($sformatf("vec%0d_addr_data_sweep", i), ok, 1);
      if (vecs[i].kind != 2 && vecs[i].kind != 4) check($sformatf("vec%0d_read_data", i), rd, vecs[i].rd);
    end

    // Tie between data and inst.
`ifdef MEM_RR_ARB_EN
    data_first = !last_data;
`else
    data_first = 1'b1;
`endif
    bus.addr_from_data = 32'h2000; bus.rw_flag_from_data = 0; bus.valid_from_data = 1;
    bus.addr_from_inst = 32'h1234; bus.valid_from_inst = 1;
    t_d = -1; t_i = -1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (bus.ready_to_data) begin t_d = c; bus.valid_from_data = 0; end
      if (bus.ready_to_inst) begin t_i = c; bus.valid_from_inst = 0; end
      if (t_d > 0 && t_i > 0) break;
    end
    check("tie_data_ready_cycle", t_d, data_first ? 18 : 36);
    check("tie_inst_ready_cycle", t_i, data_first ? 36 : 18);
    check("tie_line_data", bus.line_to_data, ref_line(32'h2000));
    check("tie_line_inst", bus.line_to_inst, ref_line(32'h1230));
    last_data = !data_first;

    // IO write held off by io_buffer_full.
    bus.io_buffer_full = 1; bus.valid_from_io = 1; bus.rw_flag_from_io = 1;
    bus.addr_from_io = 32'h3_0000; bus.byte_from_io = 8'h41;
    nblk = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.mem_wr || bus.ready_to_io) nblk++;
    end
    check("io_blocked_no_write", nblk, 0);
    bus.io_buffer_full = 0;
    @(posedge clk); #1;
    bus.valid_from_io = 0;
    check("io_unblocked_write", {bus.mem_wr, bus.mem_a, bus.mem_dout}, {1'b1, 32'h3_0000, 8'h41});
    @(posedge clk); #1;
    check("io_unblocked_ready", {bus.ready_to_io, bus.mem_wr}, 2'b10);
    ref_mem[32'h3_0000] = 8'h41;

    // Blocked IO write must not stall an inst request.
    bus.io_buffer_full = 1; bus.valid_from_io = 1; bus.addr_from_io = 32'h3_0001; bus.byte_from_io = 8'h42;
    bus.valid_from_inst = 1; bus.addr_from_inst = 32'h1234;
    t_i = -1; nblk = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (bus.mem_wr || bus.ready_to_io) nblk++;
      if (bus.ready_to_inst) begin t_i = c; bus.valid_from_inst = 0; break; end
    end
    check("blk_inst_ready_cycle", t_i, 18);
    check("blk_io_held", nblk, 0);
    check("blk_inst_line", bus.line_to_inst, ref_line(32'h1230));
    last_data = 1'b0;
    bus.io_buffer_full = 0; t_io = -1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (bus.mem_wr) bus.valid_from_io = 0;
      if (bus.ready_to_io) begin t_io = c; break; end
    end
    bus.valid_from_io = 0;
    check("blk_io_ready_cycle", t_io, 2);
    ref_mem[32'h3_0001] = 8'h42;

    // Reset in the middle of a line write.
    bus.addr_from_data = 32'h5000; bus.rw_flag_from_data = 1; bus.line_from_data = seq_line(8'h10);
    bus.valid_from_data = 1;
    @(posedge clk); #1;
    bus.valid_from_data = 0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_write_byte7", {bus.mem_wr, bus.mem_a, bus.mem_dout}, {1'b1, 32'h5007, 8'h17});
    rst = 1;
    @(posedge clk); #1;
    check("abort_outputs", {bus.mem_wr, bus.ready_to_data, bus.mem_a}, 34'h0);
    rst = 0;
    nblk = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.ready_to_data || bus.mem_wr) nblk++;
    end
    check("abort_no_ready", nblk, 0);
    last_data = 1'b0;
    txn(0, 32'h1234, '0, 8'h00, lat, nwr, ok, rd);
    check("post_abort_latency", lat, 17);
    check("post_abort_line", rd, ref_line(32'h1234));

    // rdy low freezes a line write and gates mem_wr.
    bus.addr_from_data = 32'h6000; bus.rw_flag_from_data = 1; bus.line_from_data = seq_line(8'h60);
    bus.valid_from_data = 1;
    @(posedge clk); #1;
    bus.valid_from_data = 0;
    repeat (4) @(posedge clk);
    #1;
    rdy = 0;
    #1;
    check("rdy_low_gates_wr", {bus.mem_wr, bus.mem_a}, {1'b0, 32'h6004});
    repeat (3) @(posedge clk);
    #1;
    check("rdy_low_frozen", {bus.mem_wr, bus.mem_a, bus.ready_to_data}, {1'b0, 32'h6004, 1'b0});
    rdy = 1;
    t_d = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus.ready_to_data) begin t_d = c; break; end
    end
    check("rdy_resume_edges", t_d, 12);
    for (int k = 0; k < LB; k++) ref_mem[32'h6000 + 32'(k)] = 8'(8'h60 + 8'(k));
    last_data = 1'b1;
    txn(1, 32'h600A, '0, 8'h00, lat, nwr, ok, rd);
    check("rdy_readback", rd, ref_line(32'h6000));

    // Randomised traffic against the transaction-level model.
    for (int i = 0; i < 24; i++) begin
      int kind;
      logic [31:0] addr;
      logic [LW-1:0] wl;
      logic [LW-1:0] exp;
      kind = $urandom_range(0, 4);
      addr = 32'h4000 + 32'($urandom_range(0, 63));
      wl = {$urandom, $urandom, $urandom, $urandom};
      exp = (kind <= 1) ? ref_line(addr) : LW'(ref_rd(addr));
      txn(kind, addr, wl, 8'($urandom), lat, nwr, ok, rd);
      check($sformatf("rnd%0d_k%0d_latency", i, kind), lat, lat_of(kind));
      check($sformatf("rnd%0d_k%0d_sweep", i, kind), ok, 1);
      if (kind == 0 || kind == 1 || kind == 3) check($sformatf("rnd%0d_k%0d_read", i, kind), rd, exp);
      if (kind == 2) check($sformatf("rnd%0d_wr_cycles", i), nwr, LB);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
- Sole owner of the byte-wide RAM/IO port.
- Serves three requesters: instruction fetcher (line read), load/store buffer cache (line read/write) and load/store buffer IO path (single-byte read/write).
- Grants one transaction at a time, serialises it into byte accesses, and returns a one-cycle ready pulse to the granted requester.

Parameters:
- LINE_BYTES, 16, bytes per cache line; power of two, at least 4.
- OFFSET_BITS, 4, log2(LINE_BYTES).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- valid_from_inst  in  1  instruction line-read request
- addr_from_inst  in  32  fetch address
- ready_to_inst  out  1  one-cycle done pulse
- line_to_inst  out  8*LINE_BYTES  line read; byte 0 in bits [7:0]
- valid_from_data  in  1  data line request
- rw_flag_from_data  in  1  0 = read, 1 = write
- addr_from_data  in  32  data address
- line_from_data  in  8*LINE_BYTES  write line
- ready_to_data  out  1  one-cycle done pulse
- line_to_data  out  8*LINE_BYTES  line read
- valid_from_io  in  1  IO byte request
- rw_flag_from_io  in  1  0 = read, 1 = write
- addr_from_io  in  32  IO address
- byte_from_io  in  8  write byte
- ready_to_io  out  1  one-cycle done pulse
- byte_to_io  out  8  byte read
- mem_din  in  8  RAM read data; valid one cycle after mem_a is presented
- mem_dout  out  8  RAM write data
- mem_a  out  32  RAM address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  IO sink cannot accept writes

Behaviour:
- Reset values: state IDLE, byte counter 0, all ready outputs 0, mem_wr 0, mem_a 0, mem_dout 0, line/byte outputs 0, round-robin pointer to inst.
- rst aborts any transaction in flight. No ready pulse is issued for an aborted transaction.
- rdy low: no register changes. mem_wr output is forced to 0 combinationally.
- States: IDLE, LINE_READ, LINE_WRITE, IO_READ, IO_WRITE.
- IDLE arbitration, fixed priority io > data > inst. A request is sampled only while in IDLE.
- IO write is not eligible while io_buffer_full=1. The data and inst requests may still be granted in that cycle.
- Line base address = requested address with bits [OFFSET_BITS-1:0] cleared.
- Numbering: E0 is the edge at which a request is granted.
- LINE_READ:
  - Byte j is addressed at edge Ej.
  - mem_din is captured into line byte j at edge Ej+2.
  - ready goes high after edge E(LINE_BYTES+1), together with the complete line.
  - mem_a beyond the last byte is don't-care; mem_wr stays 0.
- LINE_WRITE:
  - mem_wr=1, with byte j of line_from_data driven at edge Ej.
  - At edge E(LINE_BYTES): mem_wr<=0 and ready_to_data<=1.
  - line_from_data and addr are latched at E0. The requester may change them afterwards.
- IO_READ: address driven at E0; mem_din captured into byte_to_io at E2; ready_to_io high after E2.
- IO_WRITE: byte driven with mem_wr=1 at E0; at E1, mem_wr<=0 and ready_to_io<=1.
- Ready is a single-cycle pulse. The state returns to IDLE on the same edge that raises ready, so the next grant is sampled the cycle ready is high.
- A requester must deassert valid, or present a new request, in the cycle following ready. A request still asserted then is treated as a new transaction.
- A requester dropping valid mid-transaction does not abort it. The transaction completes and the ready pulse is still issued.
- Read outputs hold their value until the next read completes for that requester.
- Address arithmetic is 32-bit and wraps modulo 2^32.

Optional Feature:
MEM_RR_ARB_EN:
- Defined: IO keeps top priority. Between data and inst, the one not granted last wins a tie; the pointer updates at each data or inst grant.
- Undefined: fixed priority io > data > inst.

Test Plan:
- Inst read 0x00001234, RAM byte k = k & 0xFF: mem_a sweeps 0x1230..0x123F; ready_to_inst pulses once, 17 edges after grant; line_to_inst bytes = 0x30..0x3F.
- Data write to 0x2000, line = bytes 0xA0..0xAF: mem_wr high exactly 16 cycles at 0x2000..0x200F; ready_to_data after 16 edges; a subsequent data read returns 0xA0..0xAF.
- Inst and data valid in the same cycle: without the macro, data is served first, then inst. With MEM_RR_ARB_EN on repeated ties, grants alternate data, inst, data.
- IO write 0x30000 byte 0x41 with io_buffer_full=1 for 5 cycles: no mem_wr during the 5 cycles; write issued on the first cycle full=0; ready_to_io one edge later. A simultaneous inst request is granted while the IO write is blocked.
- IO read 0x30004 with mem_din=0x7F: byte_to_io=0x7F; ready_to_io pulses 2 edges after grant.
- rst asserted mid-LINE_WRITE (byte 7): mem_wr=0 next cycle, no ready pulse, state IDLE; a new inst request then completes normally.
